// File: rtl/antirrebote_pkg.sv
// Shared types and defaults for the push-button debouncer.
package antirrebote_pkg;

    typedef enum logic [1:0] {
        ESTABLE_BAJO,
        VALIDANDO_ALTO,
        ESTABLE_ALTO,
        VALIDANDO_BAJO
    } estado_antirrebote_t;

    // 10 ms at 100 MHz
    localparam int unsigned CICLOS_ESTABLE_DEF = 1_000_000;

endpackage

// File: rtl/antirrebote_canal.sv
// One button channel: two-flop synchroniser, debounce FSM with run counter,
// registered level and one-cycle press pulse.
module antirrebote_canal
    import antirrebote_pkg::*;
#(
    parameter int unsigned CICLOS_ESTABLE = CICLOS_ESTABLE_DEF
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic boton_i,
    output logic nivel_o,
    output logic pulso_o
);

    localparam int unsigned CNT_W = $clog2(CICLOS_ESTABLE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CICLOS_ESTABLE - 1);
    localparam logic [CNT_W-1:0] CNT_UNO = CNT_W'(1);

    if (CICLOS_ESTABLE < 2) begin : g_chk_param
        $error("antirrebote_canal: CICLOS_ESTABLE must be >= 2");
    end

    logic                sync1_q;
    logic                sync2_q;
    estado_antirrebote_t estado_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                nivel_q;
    logic                pulso_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            estado_q <= ESTABLE_BAJO;
            cnt_q    <= '0;
            nivel_q  <= 1'b0;
            pulso_q  <= 1'b0;
        end else begin
            sync1_q <= boton_i;
            sync2_q <= sync1_q;
            pulso_q <= 1'b0;
            // Any opposite sample while validating aborts back to the stable state.
            case (estado_q)
                ESTABLE_BAJO: begin
                    if (sync2_q) begin
                        estado_q <= VALIDANDO_ALTO;
                        cnt_q    <= CNT_UNO;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                VALIDANDO_ALTO: begin
                    if (!sync2_q) begin
                        estado_q <= ESTABLE_BAJO;
                        cnt_q    <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        estado_q <= ESTABLE_ALTO;
                        cnt_q    <= '0;
                        nivel_q  <= 1'b1;
                        pulso_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_UNO;
                    end
                end
                ESTABLE_ALTO: begin
                    if (!sync2_q) begin
                        estado_q <= VALIDANDO_BAJO;
                        cnt_q    <= CNT_UNO;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                VALIDANDO_BAJO: begin
                    if (sync2_q) begin
                        estado_q <= ESTABLE_ALTO;
                        cnt_q    <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        estado_q <= ESTABLE_BAJO;
                        cnt_q    <= '0;
                        nivel_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_UNO;
                    end
                end
                default: begin
                    estado_q <= ESTABLE_BAJO;
                    cnt_q    <= '0;
                    nivel_q  <= 1'b0;
                end
            endcase
        end
    end

    assign nivel_o = nivel_q;
    assign pulso_o = pulso_q;

endmodule

// File: rtl/antirrebote_botones.sv
// Input conditioning for the dice game: N independent debounced button channels
// feeding the game core's lanzar_pi.
module antirrebote_botones
    import antirrebote_pkg::*;
#(
    parameter int unsigned N_BOTONES      = 2,
    parameter int unsigned CICLOS_ESTABLE = CICLOS_ESTABLE_DEF
) (
    input  logic                 clk_pi,
    input  logic                 rst_n_pi,
    input  logic [N_BOTONES-1:0] botones_pi,
    output logic [N_BOTONES-1:0] botones_po,
    output logic [N_BOTONES-1:0] pulsos_po
);

    for (genvar i = 0; i < N_BOTONES; i++) begin : g_canal
        antirrebote_canal #(
            .CICLOS_ESTABLE(CICLOS_ESTABLE)
        ) u_canal (
            .clk_i   (clk_pi),
            .rst_n_i (rst_n_pi),
            .boton_i (botones_pi[i]),
            .nivel_o (botones_po[i]),
            .pulso_o (pulsos_po[i])
        );
    end

endmodule

// File: tb/tb_antirrebote_botones.sv
// Directed bench for antirrebote_botones with a run-length reference model
// feeding a scoreboard queue, plus latency/pulse-count checks per scenario.
module tb_antirrebote_botones;

    localparam int unsigned N  = 2;
    localparam int unsigned CE = 4;

    logic         clk_pi = 1'b0;
    logic         rst_n_pi = 1'b0;
    logic [N-1:0] botones_pi = '1;
    logic [N-1:0] botones_po;
    logic [N-1:0] pulsos_po;

    antirrebote_botones #(
        .N_BOTONES      (N),
        .CICLOS_ESTABLE (CE)
    ) dut (
        .clk_pi     (clk_pi),
        .rst_n_pi   (rst_n_pi),
        .botones_pi (botones_pi),
        .botones_po (botones_po),
        .pulsos_po  (pulsos_po)
    );

    initial forever #5 clk_pi = ~clk_pi;

    // Reference: level flips once the synchronised sample has disagreed with it
    // on CE consecutive edges.
    logic         m_s1 [N];
    logic         m_s2 [N];
    logic         m_lvl[N];
    int           m_run[N];
    logic [2*N-1:0] sb_q[$];

    int checks = 0;
    int errors = 0;
    int edge_n;
    int rise_edge[N];
    int fall_edge[N];
    int pulse_cnt[N];
    logic [N-1:0] prev_b;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelo_zero();
        for (int i = 0; i < N; i++) begin
            m_s1[i]  = 1'b0;
            m_s2[i]  = 1'b0;
            m_lvl[i] = 1'b0;
            m_run[i] = 0;
        end
    endtask

    task automatic modelo_flanco(input logic [N-1:0] raw, input logic rstn);
        logic [N-1:0] e_lvl;
        logic [N-1:0] e_pul;
        logic         s;
        e_pul = '0;
        if (!rstn) modelo_zero();
        for (int i = 0; i < N; i++) begin
            if (rstn) begin
                s       = m_s2[i];
                m_s2[i] = m_s1[i];
                m_s1[i] = raw[i];
                if (s !== m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == int'(CE)) begin
                        m_lvl[i] = s;
                        m_run[i] = 0;
                        e_pul[i] = s;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            e_lvl[i] = m_lvl[i];
        end
        sb_q.push_back({e_lvl, e_pul});
    endtask

    task automatic paso(input logic [N-1:0] raw, input logic rstn, input string tag);
        logic [2*N-1:0] exp;
        logic [2*N-1:0] obs;
        botones_pi = raw;
        rst_n_pi   = rstn;
        @(posedge clk_pi);
        modelo_flanco(raw, rstn);
        #1;
        exp = sb_q.pop_front();
        obs = {botones_po, pulsos_po};
        chk(tag, int'(obs), int'(exp));
        edge_n++;
        for (int i = 0; i < N; i++) begin
            if (botones_po[i] && !prev_b[i]) rise_edge[i] = edge_n;
            if (!botones_po[i] && prev_b[i]) fall_edge[i] = edge_n;
            if (pulsos_po[i]) pulse_cnt[i]++;
        end
        prev_b = botones_po;
    endtask

    task automatic inicio_escenario();
        edge_n = 0;
        prev_b = botones_po;
        for (int i = 0; i < N; i++) begin
            rise_edge[i] = -1;
            fall_edge[i] = -1;
            pulse_cnt[i] = 0;
        end
    endtask

    task automatic reset_async(input string tag);
        #2;
        rst_n_pi = 1'b0;
        modelo_zero();
        #1;
        chk(tag, int'({botones_po, pulsos_po}), 0);
    endtask

    initial begin
        modelo_zero();
        inicio_escenario();

        // 1. reset held with both buttons pressed
        for (int k = 0; k < 20; k++) paso(2'b11, 1'b0, "reset_hold");
        for (int k = 0; k < 6; k++)  paso(2'b00, 1'b1, "idle");

        // 2. clean press on channel 0
        inicio_escenario();
        for (int k = 0; k < 20; k++) paso(2'b01, 1'b1, "press0");
        chk("press0_rise_edge", rise_edge[0], 6);
        chk("press0_pulses", pulse_cnt[0], 1);
        chk("press0_ch1_quiet", rise_edge[1], -1);

        // 4a. 3-cycle low glitch while high
        inicio_escenario();
        for (int k = 0; k < 3; k++) paso(2'b00, 1'b1, "glitch_low");
        for (int k = 0; k < 8; k++) paso(2'b01, 1'b1, "glitch_recover");
        chk("glitch_no_fall", fall_edge[0], -1);
        chk("glitch_level", int'(botones_po[0]), 1);

        // 4b. release
        inicio_escenario();
        for (int k = 0; k < 10; k++) paso(2'b00, 1'b1, "release0");
        chk("release0_fall_edge", fall_edge[0], 6);
        chk("release0_no_pulse", pulse_cnt[0], 0);

        // 3. bounce then steady press
        inicio_escenario();
        for (int k = 0; k < 12; k++) paso(((k / 2) % 2 == 0) ? 2'b01 : 2'b00, 1'b1, "bounce");
        chk("bounce_no_rise", rise_edge[0], -1);
        chk("bounce_no_pulse", pulse_cnt[0], 0);
        inicio_escenario();
        for (int k = 0; k < 12; k++) paso(2'b01, 1'b1, "bounce_steady");
        chk("bounce_rise_edge", rise_edge[0], 6);
        chk("bounce_pulses", pulse_cnt[0], 1);
        for (int k = 0; k < 10; k++) paso(2'b00, 1'b1, "bounce_release");

        // 5. simultaneous press
        inicio_escenario();
        for (int k = 0; k < 10; k++) paso(2'b11, 1'b1, "both");
        chk("both_rise0", rise_edge[0], 6);
        chk("both_rise1", rise_edge[1], 6);
        chk("both_pulses0", pulse_cnt[0], 1);
        chk("both_pulses1", pulse_cnt[1], 1);

        // async reset clears high outputs immediately
        reset_async("async_clear_high");
        for (int k = 0; k < 3; k++) paso(2'b00, 1'b0, "reset_low");
        for (int k = 0; k < 4; k++) paso(2'b00, 1'b1, "idle2");

        // 6. reset mid-validation on channel 1
        inicio_escenario();
        for (int k = 0; k < 3; k++) paso(2'b10, 1'b1, "mid_press1");
        reset_async("mid_reset");
        for (int k = 0; k < 4; k++) paso(2'b10, 1'b0, "mid_reset_hold");
        inicio_escenario();
        for (int k = 0; k < 12; k++) paso(2'b10, 1'b1, "post_reset");
        chk("post_reset_rise1", rise_edge[1], 6);
        chk("post_reset_pulses1", pulse_cnt[1], 1);
        chk("post_reset_ch0_quiet", rise_edge[0], -1);

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
